// File: rtl/sat_bin_pkg.sv
// Shared types and constants for the clause bin transfer controller.
package sat_bin_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CLEAR = 3'd2,
        RD    = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } xfer_state_t;

    // Two-bit literal encoding used inside clause words.
    localparam logic [1:0] LIT_NONE = 2'b00;
    localparam logic [1:0] LIT_POS  = 2'b01;
    localparam logic [1:0] LIT_NEG  = 2'b10;

    // Bits needed to hold a slot index or a slot count of 0..n.
    function automatic int cidx_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/slot_onehot_dec.sv
// Slot index to one-hot decoder with enable; all-zero when disabled.
module slot_onehot_dec
    import sat_bin_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int IDX_W     = cidx_width(NUM_SLOTS)
) (
    input  logic                 en_i,
    input  logic [IDX_W-1:0]     idx_i,
    output logic [NUM_SLOTS-1:0] onehot_o
);

    // Out-of-range indices decode to zero, so the output is never multi-hot.
    always_comb begin
        onehot_o = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (en_i && (idx_i == IDX_W'(s))) begin
                onehot_o[s] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clause_bin_xfer.sv
// Clause array load/unload controller: streams clauses into array slots,
// zero-fills the unused slots, and streams slots back out on unload.
module clause_bin_xfer
    import sat_bin_pkg::*;
#(
    parameter int NUM_VARS    = 8,
    parameter int NUM_CLAUSES = 8,
    parameter int WIDTH_C_LEN = 4,
    parameter int WIDTH_CIDX  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_load_i,
    input  logic                               start_unload_i,
    input  logic [WIDTH_CIDX-1:0]              num_clauses_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [NUM_VARS*2-1:0]              in_clause_i,
    input  logic [WIDTH_C_LEN-1:0]             in_len_i,
    output logic [NUM_CLAUSES-1:0]             wr_o,
    output logic [NUM_CLAUSES-1:0]             rd_o,
    output logic [NUM_VARS*2-1:0]              clause_o,
    output logic [WIDTH_C_LEN-1:0]             clause_len_o,
    input  logic [NUM_VARS*2-1:0]              clause_i,
    input  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [NUM_VARS*2-1:0]              out_clause_o,
    output logic [WIDTH_C_LEN-1:0]             out_len_o,
    output logic                               out_last_o,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam int                    CW        = NUM_VARS * 2;
    localparam logic [WIDTH_CIDX-1:0] NC        = WIDTH_CIDX'(NUM_CLAUSES);
    localparam logic [WIDTH_CIDX-1:0] LAST_SLOT = WIDTH_CIDX'(NUM_CLAUSES - 1);

    xfer_state_t             state_q, state_d;
    logic [WIDTH_CIDX-1:0]   idx_q, idx_d;
    logic [WIDTH_CIDX-1:0]   cnt_q, cnt_d;
    logic [WIDTH_CIDX-1:0]   idx_inc;
    logic [WIDTH_CIDX-1:0]   num_sat;

    logic [NUM_CLAUSES-1:0]  wr_q, wr_d;
    logic [CW-1:0]           wdata_q, wdata_d;
    logic [WIDTH_C_LEN-1:0]  wlen_q, wlen_d;

    logic [CW-1:0]           oclause_q, oclause_d;
    logic [WIDTH_C_LEN-1:0]  olen_q, olen_d;
    logic                    olast_q, olast_d;

    logic                    hs_in;
    logic                    dec_en;
    logic [NUM_CLAUSES-1:0]  dec_oh;
    logic [WIDTH_C_LEN-1:0]  rd_len;

    assign idx_inc = idx_q + 1'b1;
    assign num_sat = (num_clauses_i > NC) ? NC : num_clauses_i;

    // Only LOAD accepts beats; idx_q < cnt_q always holds there.
    assign in_ready_o = (state_q == LOAD) && (idx_q < cnt_q);
    assign hs_in      = in_valid_i & in_ready_o;

    // One decoder serves both strobes: a load beat, a clear slot, or a read.
    assign dec_en = hs_in | (state_q == CLEAR) | (state_q == RD);

    slot_onehot_dec #(
        .NUM_SLOTS (NUM_CLAUSES),
        .IDX_W     (WIDTH_CIDX)
    ) u_dec (
        .en_i     (dec_en),
        .idx_i    (idx_q),
        .onehot_o (dec_oh)
    );

    // Reads are combinational so the array's data is captured in the same
    // cycle; writes are registered so data and strobe leave together.
    assign rd_o = (state_q == RD) ? dec_oh : '0;
    assign wr_d = (state_q == RD) ? '0 : dec_oh;

    // Write data is zero for clear slots and for idle cycles.
    assign wdata_d = hs_in ? in_clause_i : '0;
    assign wlen_d  = hs_in ? in_len_i    : '0;

    // Select the length field of the slot currently being read.
    always_comb begin
        rd_len = '0;
        for (int s = 0; s < NUM_CLAUSES; s++) begin
            if (idx_q == WIDTH_CIDX'(s)) begin
                rd_len = clause_len_i[s*WIDTH_C_LEN +: WIDTH_C_LEN];
            end
        end
    end

    // Next-state, slot index and unload capture logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        oclause_d = oclause_q;
        olen_d    = olen_q;
        olast_d   = olast_q;
        unique case (state_q)
            IDLE: begin
                // Load takes priority when both starts are seen together.
                if (start_load_i) begin
                    cnt_d   = num_sat;
                    idx_d   = '0;
                    state_d = (num_sat == '0) ? CLEAR : LOAD;
                end else if (start_unload_i) begin
                    cnt_d   = num_sat;
                    idx_d   = '0;
                    state_d = (num_sat == '0) ? DONE : RD;
                end
            end
            LOAD: begin
                if (hs_in) begin
                    idx_d = idx_inc;
                    if (idx_inc == cnt_q) begin
                        state_d = (cnt_q == NC) ? DONE : CLEAR;
                    end
                end
            end
            CLEAR: begin
                idx_d = idx_inc;
                if (idx_q == LAST_SLOT) begin
                    state_d = DONE;
                end
            end
            RD: begin
                oclause_d = clause_i;
                olen_d    = rd_len;
                olast_d   = (idx_inc == cnt_q);
                state_d   = OUT;
            end
            OUT: begin
                if (out_ready_i) begin
                    idx_d   = idx_inc;
                    state_d = olast_q ? DONE : RD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, index and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            wr_q      <= '0;
            wdata_q   <= '0;
            wlen_q    <= '0;
            oclause_q <= '0;
            olen_q    <= '0;
            olast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            wlen_q    <= wlen_d;
            oclause_q <= oclause_d;
            olen_q    <= olen_d;
            olast_q   <= olast_d;
        end
    end

    assign wr_o         = wr_q;
    assign clause_o     = wdata_q;
    assign clause_len_o = wlen_q;
    assign out_valid_o  = (state_q == OUT);
    assign out_clause_o = oclause_q;
    assign out_len_o    = olen_q;
    assign out_last_o   = olast_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);

endmodule

// File: tb/tb_clause_bin_xfer.sv
// Self-checking bench for clause_bin_xfer with a queue-based reference model.
module tb_clause_bin_xfer;

    localparam int NV = 8;
    localparam int NC = 8;
    localparam int WL = 4;
    localparam int WI = 4;
    localparam int CW = NV * 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_load_i, start_unload_i;
    logic [WI-1:0]     num_clauses_i;
    logic              in_valid_i, in_ready_o;
    logic [CW-1:0]     in_clause_i;
    logic [WL-1:0]     in_len_i;
    logic [NC-1:0]     wr_o, rd_o;
    logic [CW-1:0]     clause_o, clause_i;
    logic [WL-1:0]     clause_len_o;
    logic [WL*NC-1:0]  clause_len_i;
    logic              out_valid_o, out_ready_i;
    logic [CW-1:0]     out_clause_o;
    logic [WL-1:0]     out_len_o;
    logic              out_last_o, busy_o, done_o;

    typedef struct {
        int            cyc;
        logic [NC-1:0] oh;
        logic [CW-1:0] c;
        logic [WL-1:0] l;
        logic          last;
    } ev_t;

    ev_t wr_log[$];
    ev_t rd_log[$];
    ev_t hs_log[$];
    ev_t out_log[$];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    // Array contents seen by unload, and beats offered by load.
    logic [CW-1:0] mem_clause [NC];
    logic [WL-1:0] mem_len    [NC];
    logic [CW-1:0] beat_c     [NC];
    logic [WL-1:0] beat_l     [NC];

    clause_bin_xfer #(
        .NUM_VARS(NV), .NUM_CLAUSES(NC), .WIDTH_C_LEN(WL), .WIDTH_CIDX(WI)
    ) dut (
        .clk(clk), .rst(rst),
        .start_load_i(start_load_i), .start_unload_i(start_unload_i),
        .num_clauses_i(num_clauses_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_clause_i(in_clause_i), .in_len_i(in_len_i),
        .wr_o(wr_o), .rd_o(rd_o),
        .clause_o(clause_o), .clause_len_o(clause_len_o),
        .clause_i(clause_i), .clause_len_i(clause_len_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_clause_o(out_clause_o), .out_len_o(out_len_o),
        .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Array model: read data follows the read strobe combinationally.
    always_comb begin
        clause_i = '0;
        for (int s = 0; s < NC; s++) begin
            if (rd_o[s]) clause_i = clause_i | mem_clause[s];
        end
    end
    always_comb begin
        clause_len_i = '0;
        for (int s = 0; s < NC; s++) clause_len_i[s*WL +: WL] = mem_len[s];
    end

    // Monitor: protocol invariants every cycle plus event logs for the tests.
    logic          hold_q = 1'b0;
    logic [CW-1:0] hold_c;
    logic [WL-1:0] hold_l;
    logic          hold_last;
    always @(negedge clk) begin
        if (rst) begin
            hold_q <= 1'b0;
        end else begin
            n_tests++;
            if ((wr_o & rd_o) != '0 || $countones(wr_o) > 1 || $countones(rd_o) > 1) begin
                n_fail++;
                $display("FAIL strobe_onehot cyc=%0d wr=%h rd=%h, want exclusive one-hot", cyc, wr_o, rd_o);
            end
            n_tests++;
            if (wr_o == '0 && (clause_o !== '0 || clause_len_o !== '0)) begin
                n_fail++;
                $display("FAIL idle_wdata cyc=%0d clause=%h len=%h, want 0", cyc, clause_o, clause_len_o);
            end
            if (hold_q) begin
                n_tests++;
                if (out_valid_o !== 1'b1 || out_clause_o !== hold_c || out_len_o !== hold_l ||
                    out_last_o !== hold_last) begin
                    n_fail++;
                    $display("FAIL out_hold cyc=%0d v=%b c=%h l=%h last=%b, want v=1 c=%h l=%h last=%b",
                             cyc, out_valid_o, out_clause_o, out_len_o, out_last_o, hold_c, hold_l, hold_last);
                end
            end
            if (wr_o != '0) wr_log.push_back('{cyc, wr_o, clause_o, clause_len_o, 1'b0});
            if (rd_o != '0) rd_log.push_back('{cyc, rd_o, '0, '0, 1'b0});
            if (in_valid_i && in_ready_o) hs_log.push_back('{cyc, '0, in_clause_i, in_len_i, 1'b0});
            if (out_valid_o && out_ready_i)
                out_log.push_back('{cyc, '0, out_clause_o, out_len_o, out_last_o});
            hold_q    <= out_valid_o && !out_ready_i;
            hold_c    <= out_clause_o;
            hold_l    <= out_len_o;
            hold_last <= out_last_o;
        end
    end

    task automatic clear_logs();
        wr_log.delete(); rd_log.delete(); hs_log.delete(); out_log.delete();
    endtask

    // One-cycle start pulse; returns the cycle in which it was presented.
    task automatic kick(input bit ld, input bit ul, input int num, output int sc);
        @(posedge clk); #1;
        start_load_i   = ld;
        start_unload_i = ul;
        num_clauses_i  = WI'(num);
        sc             = cyc;
        @(posedge clk); #1;
        start_load_i   = 1'b0;
        start_unload_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({wr_o, rd_o, in_ready_o, out_valid_o, out_clause_o, out_len_o, out_last_o,
             busy_o, done_o, clause_o, clause_len_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs wr=%h rd=%h busy=%b done=%b ov=%b, want all 0",
                     wr_o, rd_o, busy_o, done_o, out_valid_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Load scenario. mode: 0 valid always, 1 valid on steps 0,3,4.., 2 random.
    task automatic test_load_case(input string name, input int num, input int mode, input bit both);
        int cnt, k, step, sc, dcyc;
        bit seen;
        cnt = (num > NC) ? NC : num;
        for (int i = 0; i < NC; i++) begin
            beat_c[i] = CW'($urandom) | CW'(1);
            beat_l[i] = WL'($urandom);
        end
        clear_logs();
        kick(1'b1, both, num, sc);
        k = 0;
        step = 0;
        while (k < cnt && step < 200) begin
            case (mode)
                0:       in_valid_i = 1'b1;
                1:       in_valid_i = (step == 0) || (step >= 3);
                default: in_valid_i = ($urandom_range(0, 2) != 0);
            endcase
            in_clause_i = beat_c[k];
            in_len_i    = beat_l[k];
            @(negedge clk);
            if (in_valid_i && in_ready_o) k++;
            @(posedge clk); #1;
            step++;
        end
        in_valid_i = 1'b0;
        seen = 0;
        dcyc = 0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clk);
            if (done_o) begin seen = 1; dcyc = cyc; end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s done_timeout beats=%0d, want done within budget", name, k);
        end
        @(negedge clk);
        n_tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done busy=%b done=%b, want 0 0", name, busy_o, done_o);
        end
        // Every slot is written exactly once: beats first, then zero-fill.
        n_tests++;
        if (wr_log.size() != NC || hs_log.size() != cnt) begin
            n_fail++;
            $display("FAIL %s write_count writes=%0d hs=%0d, want %0d %0d", name, wr_log.size(),
                     hs_log.size(), NC, cnt);
        end else begin
            for (int i = 0; i < NC; i++) begin
                logic [NC-1:0] eoh;
                logic [CW-1:0] ec;
                logic [WL-1:0] el;
                int            ecyc;
                eoh  = NC'(1) << i;
                ec   = (i < cnt) ? beat_c[i] : '0;
                el   = (i < cnt) ? beat_l[i] : '0;
                ecyc = (i < cnt) ? hs_log[i].cyc + 1 : (i > cnt) ? wr_log[i-1].cyc + 1 : wr_log[i].cyc;
                n_tests++;
                if (wr_log[i].oh !== eoh || wr_log[i].c !== ec || wr_log[i].l !== el ||
                    wr_log[i].cyc != ecyc || (i == cnt && cnt > 0 && wr_log[i].cyc <= wr_log[i-1].cyc)) begin
                    n_fail++;
                    $display("FAIL %s write%0d wr=%h c=%h l=%h cyc=%0d, want wr=%h c=%h l=%h cyc=%0d",
                             name, i, wr_log[i].oh, wr_log[i].c, wr_log[i].l, wr_log[i].cyc, eoh, ec, el, ecyc);
                end
            end
            n_tests++;
            if (dcyc < wr_log[NC-1].cyc) begin
                n_fail++;
                $display("FAIL %s done_early done_cyc=%0d, want >= %0d", name, dcyc, wr_log[NC-1].cyc);
            end
        end
        n_tests++;
        if (rd_log.size() != 0 || out_log.size() != 0) begin
            n_fail++;
            $display("FAIL %s stray_unload rd=%0d out=%0d, want 0 0", name, rd_log.size(), out_log.size());
        end
    endtask

    // Unload scenario. mode: 0 ready always, 1 ready low for 4 cycles, 2 random.
    task automatic test_unload_case(input string name, input int num, input int mode);
        int cnt, step, sc, dcyc;
        bit seen;
        cnt = (num > NC) ? NC : num;
        clear_logs();
        kick(1'b0, 1'b1, num, sc);
        seen = 0;
        dcyc = 0;
        for (step = 0; step < 300 && !seen; step++) begin
            case (mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = (step == 0) || (step >= 5);
                default: out_ready_i = ($urandom_range(0, 1) != 0);
            endcase
            @(negedge clk);
            if (done_o) begin seen = 1; dcyc = cyc; end
            else begin @(posedge clk); #1; end
        end
        out_ready_i = 1'b1;
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s done_timeout beats=%0d, want done within budget", name, out_log.size());
        end
        @(negedge clk);
        n_tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done busy=%b done=%b, want 0 0", name, busy_o, done_o);
        end
        if (cnt == 0) begin
            n_tests++;
            if (dcyc != sc + 1) begin
                n_fail++;
                $display("FAIL %s zero_done cyc=%0d, want %0d", name, dcyc, sc + 1);
            end
        end
        n_tests++;
        if (rd_log.size() != cnt || out_log.size() != cnt || wr_log.size() != 0) begin
            n_fail++;
            $display("FAIL %s beat_count rd=%0d out=%0d wr=%0d, want %0d %0d 0", name,
                     rd_log.size(), out_log.size(), wr_log.size(), cnt, cnt);
        end else begin
            for (int i = 0; i < cnt; i++) begin
                logic [NC-1:0] eoh;
                eoh = NC'(1) << i;
                n_tests++;
                if (rd_log[i].oh !== eoh || (i > 0 && rd_log[i].cyc != out_log[i-1].cyc + 1) ||
                    out_log[i].cyc <= rd_log[i].cyc) begin
                    n_fail++;
                    $display("FAIL %s read%0d rd=%h cyc=%0d out_cyc=%0d, want rd=%h after prior beat",
                             name, i, rd_log[i].oh, rd_log[i].cyc, out_log[i].cyc, eoh);
                end
                n_tests++;
                if (out_log[i].c !== mem_clause[i] || out_log[i].l !== mem_len[i] ||
                    out_log[i].last !== (i == cnt - 1)) begin
                    n_fail++;
                    $display("FAIL %s beat%0d c=%h l=%h last=%b, want c=%h l=%h last=%b", name, i,
                             out_log[i].c, out_log[i].l, out_log[i].last, mem_clause[i], mem_len[i], i == cnt - 1);
                end
            end
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < NC; i++) begin
            mem_clause[i] = CW'($urandom);
            mem_len[i]    = WL'($urandom);
        end
    endtask

    task automatic test_load_basic();    test_load_case("load3", 3, 0, 1'b0);   endtask
    task automatic test_load_gaps();     test_load_case("load_gaps", 3, 1, 1'b0); endtask
    task automatic test_start_both();    test_load_case("start_both", 4, 0, 1'b1); endtask
    task automatic test_load_saturate(); test_load_case("load12", 12, 0, 1'b0);  endtask
    task automatic test_load_zero();     test_load_case("load0", 0, 0, 1'b0);    endtask

    task automatic test_unload_basic();
        randomize_mem();
        mem_clause[0] = 16'h0102; mem_len[0] = 4'd3;
        mem_clause[1] = 16'h0408; mem_len[1] = 4'd0;
        test_unload_case("unload2", 2, 0);
    endtask

    task automatic test_unload_stall();
        randomize_mem();
        test_unload_case("unload_stall", 3, 1);
    endtask

    task automatic test_unload_zero();
        randomize_mem();
        test_unload_case("unload0", 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) != 0) begin
                test_load_case("rand_load", int'($urandom_range(0, 10)), 2, 1'b0);
            end else begin
                randomize_mem();
                test_unload_case("rand_unload", int'($urandom_range(0, 10)), 2);
            end
        end
    endtask

    task automatic test_reset_mid_out();
        int  sc;
        bit  seen;
        randomize_mem();
        out_ready_i = 1'b0;
        kick(1'b0, 1'b1, 3, sc);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (out_valid_o) seen = 1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rst_mid reach_out out_valid=%b, want 1", out_valid_o);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({wr_o, rd_o, in_ready_o, out_valid_o, out_clause_o, out_len_o, out_last_o,
             busy_o, done_o, clause_o, clause_len_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid outputs ov=%b c=%h l=%h busy=%b, want all 0",
                     out_valid_o, out_clause_o, out_len_o, busy_o);
        end
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy_o !== 1'b0 || wr_o !== '0 || rd_o !== '0) begin
            n_fail++;
            $display("FAIL rst_mid after_release busy=%b wr=%h rd=%h, want 0", busy_o, wr_o, rd_o);
        end
        test_load_case("load_after_rst", 3, 0, 1'b0);
    endtask

    initial begin
        start_load_i   = 1'b0;
        start_unload_i = 1'b0;
        num_clauses_i  = '0;
        in_valid_i     = 1'b0;
        in_clause_i    = '0;
        in_len_i       = '0;
        out_ready_i    = 1'b1;
        randomize_mem();
        test_reset();
        test_load_basic();
        test_load_gaps();
        test_unload_basic();
        test_unload_stall();
        test_start_both();
        test_unload_zero();
        test_load_saturate();
        test_load_zero();
        test_random();
        test_reset_mid_out();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d, want bench to finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clause_bin_xfer.md
Name: clause_bin_xfer

Overview:
Load/unload controller on the far side of the clause-array wr/rd interface. It streams clauses from the bin memory into the array, one slot per accepted beat, by driving one-hot write strobes with shared clause/length buses. After all requested slots are written, it writes zero into every remaining slot so empty slots read as all-satisfied. On an unload command it pulses one-hot read strobes, captures the returned literals and lengths, and streams them back to memory over a valid/ready port.

Parameters:
NUM_VARS, 8, variables per clause (2 literal bits each)
NUM_CLAUSES, 8, clause slots in the array
WIDTH_C_LEN, 4, clause length width
WIDTH_CIDX, 4, slot index/count width; must be >= clog2(NUM_CLAUSES+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start_load_i  in  1  begin load; sampled only in IDLE
start_unload_i  in  1  begin unload; sampled only in IDLE
num_clauses_i  in  WIDTH_CIDX  clause count, latched at start
in_valid_i  in  1  load beat valid
in_ready_o  out  1  load beat accepted when in_valid_i and in_ready_o are both high
in_clause_i  in  NUM_VARS*2  load literals
in_len_i  in  WIDTH_C_LEN  load length
wr_o  out  NUM_CLAUSES  one-hot write strobe to array
rd_o  out  NUM_CLAUSES  one-hot read strobe to array
clause_o  out  NUM_VARS*2  write data to array
clause_len_o  out  WIDTH_C_LEN  write length to array
clause_i  in  NUM_VARS*2  array read data, combinational on rd_o
clause_len_i  in  WIDTH_C_LEN*NUM_CLAUSES  per-slot lengths; 0 means reason clause
out_valid_o  out  1  unload beat valid
out_ready_i  in  1  unload sink ready
out_clause_o  out  NUM_VARS*2  unloaded literals
out_len_o  out  WIDTH_C_LEN  unloaded length
out_last_o  out  1  final unload beat
busy_o  out  1  high when not in IDLE
done_o  out  1  one-cycle pulse on completion

Behaviour:
- Reset: state IDLE; idx=0; cnt=0; every output 0.
- States: IDLE, LOAD, CLEAR, RD, OUT, DONE.
- IDLE:
  - start_load_i goes to LOAD; start_unload_i goes to RD.
  - Both high: load wins.
  - cnt = min(num_clauses_i, NUM_CLAUSES); idx = 0.
  - cnt==0 on load goes to CLEAR; cnt==0 on unload goes to DONE, with no beats.
- LOAD:
  - in_ready_o = 1 while idx < cnt.
  - On a handshake in cycle t: in cycle t+1, wr_o = onehot(idx) for exactly one cycle, and clause_o/clause_len_o are registered from the input. idx increments.
  - Back-to-back beats are allowed, at one per cycle.
  - When the last beat (idx==cnt-1) is accepted: go to CLEAR, or to DONE if cnt==NUM_CLAUSES.
- CLEAR: one cycle per slot idx..NUM_CLAUSES-1. wr_o = onehot(idx), clause_o = 0, clause_len_o = 0. Then go to DONE.
- wr_o is 0 whenever no write is being issued. clause_o and clause_len_o are 0 when wr_o is 0.
- RD:
  - rd_o = onehot(idx) for exactly one cycle.
  - At the clock edge, capture clause_i into out_clause_o and clause_len_i[idx*WIDTH_C_LEN +: WIDTH_C_LEN] into out_len_o.
  - out_last_o = (idx==cnt-1). Go to OUT.
- OUT:
  - out_valid_o = 1; data is held stable until out_ready_i.
  - On a handshake: idx increments, out_valid_o drops next cycle. Go to RD, or to DONE if the beat was last.
  - Throughput is one beat per 2 cycles minimum.
- DONE: done_o = 1 for one cycle, then IDLE.
- Start inputs are ignored outside IDLE.
- rd_o and wr_o are never asserted in the same cycle, and each is never multi-hot.
- Reset mid-operation: immediate return to IDLE. Strobes drop asynchronously, with no partial pulse after release.

Decomposition:
- Package sat_bin_pkg holds:
  - state enum xfer_state_t;
  - literal encoding constants LIT_NONE=2'b00, LIT_POS=2'b01, LIT_NEG=2'b10;
  - a slot-index width helper function.
- One sub-module, slot_onehot_dec (idx -> NUM_CLAUSES one-hot, with an enable input). It is shared by the wr_o and rd_o generation.

Test Plan:
- Load 3 clauses (num=3, NUM_CLAUSES=8), in_valid held high. Expect:
  - wr_o = 0x01, 0x02, 0x04 on consecutive cycles, each with the matching data;
  - then 5 clear writes 0x08..0x80 with zero data;
  - done_o pulse; busy_o low after it.
- Load with in_valid gaps (valid on cycles 0, 3, 4). Expect wr_o pulses one cycle after each handshake only. wr_o must be 0 in the gaps.
- Unload num=2 with clause_i returning 16'h0102 then 16'h0408, lengths {3, 0}. Expect:
  - rd_o = 0x01, then 0x02;
  - out beats (0x0102, 3, last=0) and (0x0408, 0, last=1).
- Unload with out_ready_i low for 4 cycles. Expect out_valid_o and data held, and no second rd_o until the handshake.
- Starts and count edges:
  - start_load_i and start_unload_i together: load runs.
  - num=0 unload: done_o after 1 cycle, no rd_o.
  - num=12 load: saturates to 8 writes, no CLEAR.
- Assert rst during OUT: all outputs 0 immediately. After release, busy_o=0, and a new load works from slot 0.
